// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer: state encoding, default width,
// and the prescaler width helper.
`timescale 1ns/1ps
package countdown_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned STATE_W       = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    // Bits needed to hold 0..prescale-1, never less than one bit.
    function automatic int unsigned presc_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides enabled clock cycles down to a one-cycle tick every PRESCALE cycles.
// tick is a combinational decode of the counter so the timer can act on it
// in the same cycle the prescaler reaches its last value.
`timescale 1ns/1ps
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned   PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Next prescaler value: restart on clear, wrap at LAST while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, start/stop control, optional
// auto-reload and a registered one-cycle expiry pulse.
`timescale 1ns/1ps
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   count_d;
    logic [WIDTH-1:0]   reload_q;
    logic [WIDTH-1:0]   reload_d;
    logic               busy_q;
    logic               busy_d;
    logic               expired_q;
    logic               expired_d;
    logic               clear_c;
    logic               tick_c;

    // Prescaler restarts whenever the interval is (re)started or paused.
    assign clear_c = load | stop | (start & (state_q != ST_RUN));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_c),
        .enable (state_q == ST_RUN),
        .tick   (tick_c)
    );

    // Next-state logic; stop outranks load, load outranks start and ticks.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
        end

        if (stop) begin
            state_d = ST_IDLE;
        end else if (load) begin
            if (start && (load_value != '0)) begin
                state_d = ST_RUN;
            end else if ((load_value == '0) && (state_q == ST_RUN)) begin
                // Loading zero while running cancels without an expiry.
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (count_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_c) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            expired_d = 1'b1;
                            if (auto_reload && (reload_q != '0)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (start && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign expired = expired_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter with prescaler, start/stop control and one-cycle expiry pulse.
- Complement to the team's free-running up-counter. It counts down from a programmed value instead of up from reset.
- Used as a timeout/interval generator next to the SPI logic and other peripherals.
- Single clock domain.

Parameters:
WIDTH, 32, width of count, load_value and internal reload register
PRESCALE, 1, clk cycles per decrement; legal range 1..2^16; 1 = decrement every cycle

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (clears on reset=0, independent of clk)
load  input  1  when high, capture load_value into count and reload register
load_value  input  WIDTH  initial/reload value
start  input  1  request transition to RUN
stop  input  1  request transition to IDLE (pause)
auto_reload  input  1  when high, expiry reloads from reload register and stays in RUN
count  output  WIDTH  current counter value (registered)
busy  output  1  high while state == RUN (registered)
expired  output  1  one-cycle pulse on terminal count (registered)

Behaviour:
- Reset (reset=0, async):
  - count=0, reload_reg=0, prescaler=0.
  - state=IDLE, busy=0, expired=0.
  - Reset mid-RUN aborts immediately; no expired pulse.
- States: IDLE, RUN, DONE. All transitions occur on rising clk edge.
- Priority in one cycle: reset > stop > load > start.
- load (any state):
  - count<=load_value, reload_reg<=load_value, prescaler<=0.
  - State unchanged unless start or stop is also high.
- IDLE:
  - start with next count!=0 -> RUN; prescaler restarts at 0.
  - start with count==0 -> ignored, stay IDLE.
  - Count holds.
- RUN:
  - Prescaler counts 0..PRESCALE-1. A tick occurs when prescaler==PRESCALE-1, then prescaler wraps to 0.
  - On tick with count>1: count<=count-1.
  - On tick with count==1 and (auto_reload==0 or reload_reg==0): count<=0, expired<=1, state->DONE.
  - On tick with count==1, auto_reload==1 and reload_reg!=0: count<=reload_reg, expired<=1, stay RUN. Count never shows 0 in this mode.
  - stop -> IDLE; count holds; prescaler<=0; no expired pulse. A later start resumes from the held count.
  - load during RUN restarts the interval from load_value. load_value==0 with no stop -> next cycle state IDLE, count=0, no expired pulse.
- DONE:
  - count=0, busy=0.
  - start with reload_reg!=0 -> count<=reload_reg, RUN.
  - start with reload_reg==0 -> stay DONE.
  - load with start -> uses load_value.
- expired:
  - High exactly one cycle, in the same cycle the terminal count value (0 or the reloaded value) is first visible on count.
  - Never asserted twice in a row unless PRESCALE==1, load_value==1 and auto_reload==1.
- Latency, PRESCALE=1, load N then start:
  - busy=1 after the start edge.
  - expired high in the cycle following the N-th decrement edge after start.
- Width rules: decrement is modulo-free (never below 0). Prescaler width is clog2(PRESCALE), minimum 1 bit.

Decomposition:
- Shared package/header: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH.
- One sub-module, tick_prescaler:
  - Parameter PRESCALE.
  - Inputs: clk, reset (async active-low), clear, enable.
  - Output: tick, a one-cycle pulse every PRESCALE enabled cycles.
  - countdown_timer drives enable=(state==RUN) and clear=(load|stop|start-in-IDLE/DONE).

Test Plan (clk period 25 ns; every test has a 1000-cycle timeout that fails the run):
1. Reset, then load=1 with load_value=11, then start, PRESCALE=1 -> count 11,10,...,1,0 on consecutive cycles; expired=1 for exactly one cycle with count==0; busy falls with state DONE; count stays 0 for 20 further cycles.
2. PRESCALE=4, load 3, start -> count decrements every 4 cycles; expired 12 cycles after the start edge; busy high for those 12 cycles.
3. auto_reload=1, PRESCALE=1, load 5, start -> count sequence 5,4,3,2,1,5,4,...; expired pulses every 5 cycles; 3 pulses observed; busy stays 1; count never equals 0.
4. Load 10, start, stop asserted after 4 decrements -> count holds 6 in IDLE for 10 cycles, no expired; start again -> continues 5..0; expired exactly once.
5. Assert reset=0 asynchronously mid-RUN (count=7, between clk edges) -> count=0, busy=0, expired=0 immediately, no expired pulse afterward; start with count==0 -> stays IDLE.
6. Simultaneous events:
   - load(value 4)+start in IDLE -> RUN from 4.
   - stop+start in RUN -> IDLE.
   - load(9) during RUN at count 2 -> count 9 next cycle, interval restarts, expired only after reaching 0 from 9.
